pipeline_hazard_ctrl: RTL

Hazard and forwarding controller for the five-stage pipelined MIPS core. It watches the register fields and write-back controls that the pipeline registers deliver to the Decode, Execute, Memory and Writeback stages. From these it produces stall and flush signals; `flush_ex` drives the flush input of the ID/EX register, and `stall_if`/`stall_id` gate the PC and IF/ID register. It also produces the forwarding selects, sequences the multi-cycle multiply/divide unit, and counts stall cycles.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/md_sequencer.sv | 80 ++++++++
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types, forwarding select encodings and the register
//               match helper used by the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Mult/div sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // Execute-stage operand select encodings.
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // Register 0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : md_sequencer
// Description : Tracks the multi-cycle mult/div unit. A start in IDLE or DONE
//               enters BUSY for MD_LATENCY cycles, followed by a one-cycle
//               DONE in which HI/LO are written.
// Ports       : clk_i      - clock
//               reset_i    - synchronous active-low reset
//               md_start_i - mult/div instruction present in Execute
//               md_busy_o  - unit busy (masked low during reset)
//               md_done_o  - one-cycle completion pulse (masked during reset)
// Revision    : 1.0 - initial release
// ============================================================================
module md_sequencer
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic md_start_i,
  output logic md_busy_o,
  output logic md_done_o
);

  localparam logic [4:0] LOAD_VAL = 5'(MD_LATENCY - 1);

  md_state_t  state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (md_start_i) begin
          state_d = BUSY;
          cnt_d   = LOAD_VAL;
        end
      end
      BUSY: begin
        // A start here cannot be legal: Decode is stalled on HI/LO use.
        if (cnt_q == 5'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DONE: begin
        if (md_start_i) begin
          state_d = BUSY;
          cnt_d   = LOAD_VAL;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // Outputs drop as soon as reset is applied, so an aborted operation never
  // reports busy or completion.
  assign md_busy_o = reset_i && (state_q == BUSY);
  assign md_done_o = reset_i && (state_q == DONE);

endmodule : md_sequencer
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard and forwarding controller for the five-stage MIPS
//               pipeline: load-use, branch and HI/LO stalls, taken-branch
//               flush, Execute/Decode forwarding selects, mult/div
//               sequencing and a saturating stall-cycle counter.
// Ports       : clk_i, reset_i (sync, active-low)
//               rs/rt_id5, rs/rt_ex5          - source registers (ID, EX)
//               write_reg_{ex,mem,wb}5        - destination registers
//               enable_wreg_{ex,mem,wb}       - register-write enables
//               mem_to_reg_{ex,mem}           - load in that stage
//               branch_id, branch_taken_id    - branch in Decode / taken
//               hilo_use_id, md_start_ex      - HI/LO use, mult/div start
//               stall_if/stall_id/flush_ex/flush_id - pipeline control
//               fwd_{a,b}_ex2, fwd_{a,b}_id   - forwarding selects
//               md_busy_o, md_done_o          - mult/div status
//               stall_cnt_o                   - saturating stall count
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       rs_id5,
  input  logic [4:0]       rt_id5,
  input  logic [4:0]       rs_ex5,
  input  logic [4:0]       rt_ex5,
  input  logic [4:0]       write_reg_ex5,
  input  logic [4:0]       write_reg_mem5,
  input  logic [4:0]       write_reg_wb5,
  input  logic             enable_wreg_ex,
  input  logic             enable_wreg_mem,
  input  logic             enable_wreg_wb,
  input  logic             mem_to_reg_ex,
  input  logic             mem_to_reg_mem,
  input  logic             branch_id,
  input  logic             branch_taken_id,
  input  logic             hilo_use_id,
  input  logic             md_start_ex,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_ex,
  output logic             flush_id,
  output logic [1:0]       fwd_a_ex2,
  output logic [1:0]       fwd_b_ex2,
  output logic             fwd_a_id,
  output logic             fwd_b_id,
  output logic             md_busy_o,
  output logic             md_done_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic             md_busy;
  logic             ex_hit_id, mem_hit_id;
  logic             load_use_stall, branch_stall, md_stall, any_stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  md_sequencer #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_sequencer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .md_start_i (md_start_ex),
    .md_busy_o  (md_busy),
    .md_done_o  (md_done_o)
  );

  assign md_busy_o = md_busy;

  // Does the Execute / Memory destination feed either Decode source?
  assign ex_hit_id  = reg_match(write_reg_ex5, rs_id5)  || reg_match(write_reg_ex5, rt_id5);
  assign mem_hit_id = reg_match(write_reg_mem5, rs_id5) || reg_match(write_reg_mem5, rt_id5);

  assign load_use_stall = mem_to_reg_ex && enable_wreg_ex && ex_hit_id;
  // The Decode comparator cannot take an ALU result still in Execute, nor
  // load data that is only available at the end of Memory.
  assign branch_stall   = branch_id && ((enable_wreg_ex && ex_hit_id) ||
                                        (mem_to_reg_mem && mem_hit_id));
  assign md_stall       = hilo_use_id && md_busy;
  assign any_stall      = reset_i && (load_use_stall || branch_stall || md_stall);

  assign stall_if = any_stall;
  assign stall_id = any_stall;
  assign flush_ex = any_stall || !reset_i;
  // A stalled taken branch is re-evaluated once its operands are ready.
  assign flush_id = (branch_taken_id && !any_stall) || !reset_i;

  always_comb begin
    fwd_a_ex2 = FWD_NONE;
    fwd_b_ex2 = FWD_NONE;
    fwd_a_id  = 1'b0;
    fwd_b_id  = 1'b0;
    if (reset_i) begin
      // Memory is checked last so it overrides Writeback (younger value).
      if (enable_wreg_wb  && reg_match(write_reg_wb5,  rs_ex5)) fwd_a_ex2 = FWD_WB;
      if (enable_wreg_mem && reg_match(write_reg_mem5, rs_ex5)) fwd_a_ex2 = FWD_MEM;
      if (enable_wreg_wb  && reg_match(write_reg_wb5,  rt_ex5)) fwd_b_ex2 = FWD_WB;
      if (enable_wreg_mem && reg_match(write_reg_mem5, rt_ex5)) fwd_b_ex2 = FWD_MEM;
      fwd_a_id = enable_wreg_mem && reg_match(write_reg_mem5, rs_id5);
      fwd_b_id = enable_wreg_mem && reg_match(write_reg_mem5, rt_id5);
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_id && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule : pipeline_hazard_ctrl
`default_nettype wire
